// File: rtl/detector_sched_pkg.sv
// Shared definitions for the detector scheduler slice.
//   - default NREQ / WIDTH / DET_LAT values
//   - scheduler FSM state encoding
//   - idx_width(): width of a requester index (never narrower than 1 bit)
package detector_sched_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DET_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/detector_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request levels, one per requester
//   last_grant  : index granted most recently; search starts one above it
//   en          : arbitration enable; no grant is produced while low
//   grant_valid : some enabled requester won
//   grant_id    : index of the winner
module rr_arbiter
  import detector_sched_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  input  logic            en,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_id
);

  int idx;

  // Walk the search order backwards so the last hit written is the requester
  // closest above last_grant, i.e. the round-robin winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/detector_scheduler.sv
// Time-shares one serial sequence detector among NREQ requesters.
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   req, data         : request levels and packed WIDTH-bit words (word i at [i*WIDTH +: WIDTH])
//   ack               : one-hot completion pulse for the serviced requester
//   result            : detector outputs, bit WIDTH-1 = response to the first bit shifted
//   result_valid      : completion pulse, coincident with ack
//   result_id         : index of the serviced requester
//   busy              : high whenever the FSM is not idle
//   det_rst, det_in   : reset and serial data towards the detector
//   det_out           : detector response, valid DET_LAT clocks after det_in
module detector_scheduler
  import detector_sched_pkg::*;
#(
  parameter  int NREQ    = DEF_NREQ,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DET_LAT = DEF_DET_LAT,
  localparam int IW      = idx_width(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      result,
  output logic                  result_valid,
  output logic [IW-1:0]         result_id,
  output logic                  busy,
  output logic                  det_rst,
  output logic                  det_in,
  input  logic                  det_out
);

  // One counter serves both the bit count in SHIFT and the DRAIN count.
  localparam int CW = $clog2(WIDTH + 4);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   cap_reg;
  logic [WIDTH-1:0]   cap_next;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      grant_id;
  logic [CW-1:0]      cnt;
  logic [DET_LAT-1:0] vld_pipe;
  logic               grant_valid;
  logic [IW-1:0]      arb_id;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .en          (state == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_id    (arb_id)
  );

  // vld_pipe delays "this cycle shifted a bit" by DET_LAT clocks, so its top
  // bit marks the cycle in which det_out answers that bit.
  always_comb begin
    cap_next = cap_reg;
    if (vld_pipe[DET_LAT-1]) cap_next = (cap_reg << 1) | WIDTH'(det_out);
  end

  // Outputs are registered: each branch loads the values that belong to the
  // state being entered, so det_rst/det_in/ack line up with that state.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state        <= ST_IDLE;
      ack          <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      result_id    <= '0;
      busy         <= 1'b0;
      det_rst      <= 1'b1;
      det_in       <= 1'b0;
      last_grant   <= IW'(NREQ - 1);
      grant_id     <= '0;
      shreg        <= '0;
      cap_reg      <= '0;
      cnt          <= '0;
      vld_pipe     <= '0;
    end else begin
      ack          <= '0;
      result_valid <= 1'b0;
      vld_pipe     <= (vld_pipe << 1) | DET_LAT'(state == ST_SHIFT);
      cap_reg      <= cap_next;

      case (state)
        ST_IDLE: begin
          det_rst <= 1'b0;
          if (grant_valid) begin
            shreg    <= data[arb_id*WIDTH +: WIDTH];
            grant_id <= arb_id;
            cap_reg  <= '0;
            det_rst  <= 1'b1;
            det_in   <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          det_rst <= 1'b0;
          det_in  <= shreg[WIDTH-1];
          shreg   <= shreg << 1;
          cnt     <= '0;
          state   <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (cnt == CW'(WIDTH - 1)) begin
            det_in <= 1'b0;
            cnt    <= '0;
            state  <= ST_DRAIN;
          end else begin
            det_in <= shreg[WIDTH-1];
            shreg  <= shreg << 1;
            cnt    <= cnt + 1'b1;
          end
        end

        // The last sample arrives in the final DRAIN cycle, so the result is
        // taken from cap_next rather than cap_reg.
        ST_DRAIN: begin
          if (cnt == CW'(DET_LAT - 1)) begin
            result       <= cap_next;
            result_valid <= 1'b1;
            result_id    <= grant_id;
            ack          <= NREQ'(1) << grant_id;
            state        <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/detector_scheduler.md
# detector_scheduler

Time-shares one serial sequence-detector FSM (ports `clock`, `reset`, `in`, `out`) among NREQ requesters. Each requester submits a WIDTH-bit word. The scheduler grants requesters round-robin, resets the detector, and shifts the word in MSB first. It collects the detector's `out` bit for every input bit and returns the collected vector to the granted requester. It sits between the requester ports and a single detector instance.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: bits per word (1..32).
- `DET_LAT`, 1: clocks from `det_in` driven to the matching `det_out` bit being valid (1..3).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `req` in NREQ: per-requester request level.
- `data` in NREQ*WIDTH: requester i word in bits [i*WIDTH +: WIDTH].
- `ack` out NREQ: one-cycle completion pulse, one-hot.
- `result` out WIDTH: collected detector outputs; bit WIDTH-1 corresponds to the first bit shifted.
- `result_valid` out 1: one-cycle pulse, coincident with `ack`.
- `result_id` out clog2(NREQ): index of the serviced requester.
- `busy` out 1: high in every state except IDLE.
- `det_rst` out 1: active-high reset to the detector.
- `det_in` out 1: serial bit to the detector.
- `det_out` in 1: detector output.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE
  - If any `req` is high, the arbiter picks the first requester searching from (last_grant+1) mod NREQ upward with wrap-around.
  - The winner's `data` is latched into the shift register and its index into `grant_id`. Next state is CLEAR.
  - If no `req` is high, stay in IDLE.
- CLEAR: `det_rst`=1 and `det_in`=0 for exactly 1 cycle, then SHIFT.
- SHIFT
  - Runs for exactly WIDTH cycles. `det_in` = shift register MSB, and the register shifts left each cycle.
  - A bit counter runs 0..WIDTH-1.
  - After the last bit, go to DRAIN.
- DRAIN: runs DET_LAT cycles with `det_in`=0, then DONE.
- Capture
  - `det_out` is sampled DET_LAT cycles after each SHIFT cycle.
  - Sampled bits shift into `result` from the LSB, so the first sample ends at bit WIDTH-1.
  - Exactly WIDTH samples are taken; any samples beyond those are ignored.
- DONE
  - `result_valid`=1, `ack[grant_id]`=1, `result_id`=grant_id.
  - `last_grant` is updated to grant_id. Next state is IDLE.
- Requester rules
  - A requester holds `req` high until `ack`. `data` is captured at grant, so it may change after the grant.
  - If `req` drops after grant, the transaction still completes and `ack` is still pulsed.
  - A `req` that is still high in the cycle after `ack` counts as a new request.
- Only one transaction is in flight at a time. While `busy` is high, all `req` inputs are ignored and not queued.
- `result` holds its value until the next DONE.

## Timing
- Reset (`reset`=0 at a rising edge)
  - State goes to IDLE; `ack`=0, `result_valid`=0, `result`=0, `result_id`=0, `busy`=0, `det_in`=0.
  - `det_rst`=1 while reset is held. `last_grant`=NREQ-1, so requester 0 wins first.
- Reset mid-transaction: the transaction is aborted, no `ack` is issued, and the requester must re-request.
- Latency, counting `req` seen in IDLE as cycle 0:
  - CLEAR is cycle 1.
  - SHIFT is cycles 2..WIDTH+1.
  - DRAIN is cycles WIDTH+2..WIDTH+1+DET_LAT.
  - `result_valid`/`ack` are high in cycle WIDTH+2+DET_LAT (11 with the defaults).
- Throughput: one transaction per WIDTH+DET_LAT+3 cycles. The earliest next grant is in the IDLE cycle right after DONE.
- Simultaneous requests in IDLE: resolved purely round-robin, with no fixed priority beyond search order.
- All outputs are registered.

## Structure
- Package `detector_sched_pkg`:
  - State enum (IDLE, CLEAR, SHIFT, DRAIN, DONE).
  - Default NREQ/WIDTH/DET_LAT constants.
  - Function for the index width clog2(NREQ).
- Sub-module `rr_arbiter`
  - Parameter NREQ.
  - Inputs: `req`, `last_grant`, `en`.
  - Outputs: `grant_valid`, `grant_id`. Combinational.
- Everything else (counters, shift and capture registers, FSM) lives in `detector_scheduler`.

## Test plan
- Echo stub (`det_out` = `det_in` registered once, DET_LAT=1), req[0]=1, data0=8'hA5 → `ack[0]` and `result_valid` in cycle 11, `result`=8'hA5, `result_id`=0.
- req=4'b1111 held high with distinct data 8'h01/8'h02/8'h04/8'h08 → acks in order 0,1,2,3,0, each exactly 12 cycles apart, with matching results.
- Detector FSM instance attached, data0=8'b11000000 → `det_rst` high in CLEAR, and `result` matches the bench's golden detector model bit-for-bit.
- After requester 2 finishes, req=4'b0101 → requester 0 is granted next (wrap-around), then 2; req[1] pulsed high only during SHIFT is never acked.
- `reset`=0 asserted in the 4th SHIFT cycle → next cycle IDLE, `busy`=0, `result`=0, no `ack`; after release, req[0] still high → serviced from CLEAR.
- WIDTH=1, DET_LAT=3, echo stub delayed 3 clocks, data=1'b1 → `result`=1, `result_valid` in cycle 6.
